seg7_time_reader: RTL

Display-readback monitor for the clock/alarm design: samples the six 7-segment digit buses (seconds, minutes, hours; units and tens), decodes them back to BCD, and checks that the displayed time only ever advances by exactly one second. It is the reader at the far end of the segment interface that the clock/alarm block drives. It is instantiated in benches and in on-chip self-test next to the display pins, and raises error flags and counts.

---
 rtl/seg7_time_reader_if.sv | 17 +
 rtl/seg7_time_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg7_time_reader_if.sv
// Segment buses from the clock/alarm display plus the readback monitor's results.
interface seg7_time_reader_if;
  logic        i_check_en;
  logic [6:0]  i_seg_s_u, i_seg_s_t, i_seg_m_u, i_seg_m_t, i_seg_h_u, i_seg_h_t;
  logic [23:0] o_time_bcd;
  logic        o_frame_valid, o_step_ok, o_step_err, o_stall;
  logic [7:0]  o_err_count;

  modport master (
    output i_check_en, i_seg_s_u, i_seg_s_t, i_seg_m_u, i_seg_m_t, i_seg_h_u, i_seg_h_t,
    input  o_time_bcd, o_frame_valid, o_step_ok, o_step_err, o_stall, o_err_count
  );
  modport slave (
    input  i_check_en, i_seg_s_u, i_seg_s_t, i_seg_m_u, i_seg_m_t, i_seg_h_u, i_seg_h_t,
    output o_time_bcd, o_frame_valid, o_step_ok, o_step_err, o_stall, o_err_count
  );
endinterface

// File: rtl/seg7_time_reader.sv
// Reads six 7-segment digits back to BCD and checks the shown time only advances by +1 s.
module seg7_digit_dec (
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_legal
);
  always_comb begin
    o_legal = 1'b1;
    o_digit = 4'd0;
    case (i_seg)
      7'b1111110: o_digit = 4'd0;
      7'b0110000: o_digit = 4'd1;
      7'b1101101: o_digit = 4'd2;
      7'b1111001: o_digit = 4'd3;
      7'b0110011: o_digit = 4'd4;
      7'b1011011: o_digit = 4'd5;
      7'b1011111: o_digit = 4'd6;
      7'b1110000: o_digit = 4'd7;
      7'b1111111: o_digit = 4'd8;
      7'b1111011: o_digit = 4'd9;
      default:    o_legal = 1'b0;
    endcase
  end
endmodule

module seg7_time_reader #(
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter int unsigned STALL_LIMIT    = 60_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  seg7_time_reader_if.slave bus
);
  localparam int          NUM_DIG = 6;
  localparam logic [31:0] LIMIT   = 32'(STALL_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ERR} state_t;

  logic [NUM_DIG-1:0][6:0] w_seg_in;
  logic [NUM_DIG-1:0][6:0] r_seg;
  logic                    r_chk;
  logic [NUM_DIG-1:0][3:0] w_dig;
  logic [NUM_DIG-1:0]      w_dig_ok;
  logic                    w_legal;
  logic [23:0]             w_bcd, w_succ;
  logic [7:0]              w_err_inc;

  state_t      r_state;
  logic [23:0] r_p, r_time;
  logic        r_valid, r_ok, r_err;
  logic [31:0] r_cnt;
  logic [7:0]  r_err_cnt;

  assign w_seg_in = {bus.i_seg_h_t, bus.i_seg_h_u, bus.i_seg_m_t,
                     bus.i_seg_m_u, bus.i_seg_s_t, bus.i_seg_s_u};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
      seg7_digit_dec u_dec (.i_seg(r_seg[gi]), .o_digit(w_dig[gi]), .o_legal(w_dig_ok[gi]));
    end
  endgenerate

  assign w_bcd   = w_dig;
  assign w_legal = (&w_dig_ok) && (w_dig[1] <= 4'd5) && (w_dig[3] <= 4'd5) &&
                   ((w_dig[5] < 4'd2) || ((w_dig[5] == 4'd2) && (w_dig[4] <= 4'd3)));

  function automatic logic [23:0] succ(input logic [23:0] p);
    logic [3:0] su, st, mu, mt, hu, ht;
    {ht, hu, mt, mu, st, su} = p;
    if (su != 4'd9) su = su + 4'd1;
    else begin
      su = 4'd0;
      if (st != 4'd5) st = st + 4'd1;
      else begin
        st = 4'd0;
        if (mu != 4'd9) mu = mu + 4'd1;
        else begin
          mu = 4'd0;
          if (mt != 4'd5) mt = mt + 4'd1;
          else begin
            mt = 4'd0;
            if (ht == 4'd2 && hu == 4'd3) begin ht = 4'd0; hu = 4'd0; end
            else if (hu == 4'd9) begin hu = 4'd0; ht = ht + 4'd1; end
            else hu = hu + 4'd1;
          end
        end
      end
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  assign w_succ    = succ(r_p);
  assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  // check_en travels with its frame so enable and segments are judged together
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_seg     <= '0;
      r_chk     <= 1'b0;
      r_state   <= S_IDLE;
      r_p       <= '0;
      r_time    <= '0;
      r_valid   <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_seg   <= SEG_ACTIVE_LOW ? ~w_seg_in : w_seg_in;
      r_chk   <= bus.i_check_en;
      r_valid <= w_legal;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      if (w_legal) r_time <= w_bcd;
      case (r_state)
        S_IDLE: begin
          if (w_legal && r_chk) begin
            r_state <= S_TRACK;
            r_p     <= w_bcd;
            r_cnt   <= '0;
          end
        end
        S_TRACK: begin
          if (!r_chk) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (!w_legal) begin
            r_state   <= S_ERR;
            r_err_cnt <= w_err_inc;
            r_cnt     <= '0;
          end else if (w_bcd == r_p) begin
            if (r_cnt != LIMIT) r_cnt <= r_cnt + 32'd1;
          end else if (w_bcd == w_succ) begin
            r_ok  <= 1'b1;
            r_p   <= w_bcd;
            r_cnt <= '0;
          end else begin
            r_err     <= 1'b1;
            r_err_cnt <= w_err_inc;
            r_p       <= w_bcd;
            r_cnt     <= '0;
          end
        end
        S_ERR: begin
          if (w_legal) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_time_bcd    = r_time;
  assign bus.o_frame_valid = r_valid;
  assign bus.o_step_ok     = r_ok;
  assign bus.o_step_err    = r_err;
  assign bus.o_stall       = (r_state == S_TRACK) && (r_cnt == LIMIT);
  assign bus.o_err_count   = r_err_cnt;
endmodule
